// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/host RAM port arbiter: sequencer states,
// access-owner codes and default geometry.
package mem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10,
    ACK    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_HOST = 2'b10
  } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: req[0]=CPU, req[1]=host. A tie goes to the
// requester that did not win last time.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req == 2'b11) begin
      grant = (last_owner == OWN_CPU) ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU and host ports through a
// 4-state IDLE/ACCESS/RESP/ACK sequencer; host_halt locks out new CPU grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  input  logic          host_halt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  state_t     state, state_next;
  owner_t     owner_q, last_owner;
  logic       cur_we;
  logic [1:0] eligible, grant;

  assign owner = owner_q;

  rr_arbiter2 u_rr (
    .req       (eligible),
    .last_owner(last_owner),
    .grant     (grant)
  );

  always_comb begin
    eligible[0] = cpu_req & ~cpu_ack & ~host_halt;
    eligible[1] = host_req & ~host_ack;
    state_next  = state;
    case (state)
      IDLE:    if (|eligible) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Every RAM-facing and port-facing output is a register loaded at a fixed
  // sequencer step, so mem_en and the acks are single-cycle by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      cur_we     <= 1'b0;
      owner_q    <= OWN_NONE;
      last_owner <= OWN_HOST;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            mem_en <= 1'b1;
            if (grant[0]) begin
              mem_we     <= cpu_we;
              cur_we     <= cpu_we;
              mem_addr   <= cpu_addr;
              mem_wdata  <= cpu_wdata;
              owner_q    <= OWN_CPU;
              last_owner <= OWN_CPU;
            end else begin
              mem_we     <= host_we;
              cur_we     <= host_we;
              mem_addr   <= host_addr;
              mem_wdata  <= host_wdata;
              owner_q    <= OWN_HOST;
              last_owner <= OWN_HOST;
            end
          end
        end
        RESP: begin
          if (owner_q == OWN_CPU) begin
            cpu_ack <= 1'b1;
            if (!cur_we) cpu_rdata <= mem_rdata;
          end else begin
            host_ack <= 1'b1;
            if (!cur_we) host_rdata <= mem_rdata;
          end
        end
        ACK:     owner_q <= OWN_NONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction
// model that tracks each granted access by its age in cycles.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, host_req, host_we, host_halt;
  logic [7:0]  cpu_addr, host_addr, mem_addr;
  logic [15:0] cpu_wdata, host_wdata, cpu_rdata, host_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, host_ack, mem_en, mem_we;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .host_halt(host_halt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // RAM environment: registered read, valid the cycle after mem_en.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an access is granted at an edge and then ages 1..3;
  // age 1 = RAM enable cycle, age 3 = ack cycle.
  logic [15:0] model_mem [256];
  bit          started = 0;
  bit          m_active = 0;
  int          m_age = 0;
  bit          m_host, m_we, m_last_host = 1;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [7:0]  e_addr;
  logic [15:0] e_wdata, e_cpu_rdata, e_host_rdata;

  always @(posedge clk) begin
    if (rst) begin
      if (m_active && m_age == 1 && m_we) model_mem[m_addr] = m_wdata;
      m_active = 0; m_age = 0; m_last_host = 1;
      e_addr = '0; e_wdata = '0; e_cpu_rdata = '0; e_host_rdata = '0;
      started = 1;
    end else if (m_active) begin
      if (m_age == 1 && m_we) model_mem[m_addr] = m_wdata;
      if (m_age == 2 && !m_we) begin
        if (m_host) e_host_rdata = model_mem[m_addr];
        else        e_cpu_rdata  = model_mem[m_addr];
      end
      m_age++;
      if (m_age == 4) m_active = 0;
    end else begin
      bit c, h;
      c = cpu_req && !host_halt;
      h = host_req;
      if (c || h) begin
        m_host      = (c && h) ? !m_last_host : h;
        m_last_host = m_host;
        m_we        = m_host ? host_we : cpu_we;
        m_addr      = m_host ? host_addr : cpu_addr;
        m_wdata     = m_host ? host_wdata : cpu_wdata;
        e_addr      = m_addr;
        e_wdata     = m_wdata;
        m_active    = 1;
        m_age       = 1;
      end
    end
  end

  int cpu_ack_cnt = 0, host_ack_cnt = 0, mem_en_cnt = 0, mem_we_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      logic e_en;
      e_en = m_active && m_age == 1;
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_en && m_we);
      chk("owner", owner, !m_active ? 2'd0 : (m_host ? 2'd2 : 2'd1));
      chk("cpu_ack", cpu_ack, m_active && m_age == 3 && !m_host);
      chk("host_ack", host_ack, m_active && m_age == 3 && m_host);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
      chk("host_rdata", host_rdata, e_host_rdata);
      cpu_ack_cnt  += int'(cpu_ack);
      host_ack_cnt += int'(host_ack);
      mem_en_cnt   += int'(mem_en);
      mem_we_cnt   += int'(mem_we);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 12; k++) begin
      if (owner == 2'd0) return;
      step();
    end
    chk({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic do_access(input bit host, input bit we, input logic [7:0] a,
                           input logic [15:0] d, output logic [15:0] rd, output int lat);
    if (host) begin host_we = we; host_addr = a; host_wdata = d; host_req = 1; end
    else      begin cpu_we = we;  cpu_addr = a;  cpu_wdata = d;  cpu_req = 1; end
    lat = 0;
    rd  = 'x;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (host ? host_ack : cpu_ack) begin
        lat = k;
        rd  = host ? host_rdata : cpu_rdata;
        break;
      end
    end
    cpu_req = 0;
    host_req = 0;
    if (lat == 0) chk("access_timeout", 0, 1);
  endtask

  task automatic new_cpu();
    cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 8'($urandom_range(0, 7));
    cpu_wdata = 16'($urandom);
  endtask

  task automatic new_host();
    host_we = 1'($urandom_range(0, 1)); host_addr = 8'($urandom_range(0, 7));
    host_wdata = 16'($urandom);
  endtask

  task automatic count_grants(input int want, output logic [1:0] seq [4], output int n);
    logic [1:0] prev;
    prev = owner;
    n = 0;
    for (int k = 0; k < 40 && n < want; k++) begin
      step();
      if (owner != 2'd0 && prev == 2'd0) begin seq[n] = owner; n++; end
      prev = owner;
    end
    chk("grant_count", n, want);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [1:0]  seq [4];
    int lat, n, c0, h0, e0, w0;

    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom);
      model_mem[i] = ram[i];
    end
    ram[50] = 16'h00AA; model_mem[50] = 16'h00AA;

    // 1: reset with random inputs
    rst = 1; host_halt = 0;
    new_cpu(); new_host(); cpu_req = 1; host_req = 1;
    step(); new_cpu(); new_host(); host_halt = 1;
    step();
    chk("rst_owner", owner, 0);
    chk("rst_mem_en_cnt", mem_en_cnt, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_acks", {cpu_ack, host_ack}, 0);
    cpu_req = 0; host_req = 0; host_halt = 0; rst = 0;
    step();

    // 2: CPU read of preloaded word
    e0 = mem_en_cnt; h0 = host_ack_cnt;
    do_access(0, 0, 8'd50, 16'h0, rd, lat);
    chk("t2_rdata", rd, 16'h00AA);
    chk("t2_latency", lat, 3);
    wait_idle("t2");
    chk("t2_mem_en_pulses", mem_en_cnt - e0, 1);
    chk("t2_host_ack", host_ack_cnt - h0, 0);

    // 3: host write then CPU read of same address
    w0 = mem_we_cnt;
    do_access(1, 1, 8'd101, 16'h0055, rd, lat);
    wait_idle("t3a");
    do_access(0, 0, 8'd101, 16'h0, rd, lat);
    chk("t3_rdata", rd, 16'h0055);
    wait_idle("t3b");
    chk("t3_mem_we_pulses", mem_we_cnt - w0, 1);

    // 4: fresh reset, both held high -> alternate starting with CPU
    rst = 1; step(); step(); rst = 0;
    c0 = cpu_ack_cnt; h0 = host_ack_cnt;
    cpu_we = 0; cpu_addr = 8'd10; host_we = 0; host_addr = 8'd20;
    cpu_req = 1; host_req = 1;
    count_grants(4, seq, n);
    wait_idle("t4");
    cpu_req = 0; host_req = 0;
    chk("t4_grant0", seq[0], 2'd1);
    chk("t4_grant1", seq[1], 2'd2);
    chk("t4_grant2", seq[2], 2'd1);
    chk("t4_grant3", seq[3], 2'd2);
    chk("t4_cpu_acks", cpu_ack_cnt - c0, 2);
    chk("t4_host_acks", host_ack_cnt - h0, 2);
    step(); step();

    // 5: halt locks the CPU out; release gives CPU the next grant
    c0 = cpu_ack_cnt; h0 = host_ack_cnt;
    host_halt = 1; cpu_req = 1; host_req = 1;
    count_grants(3, seq, n);
    wait_idle("t5a");
    chk("t5_host_acks", host_ack_cnt - h0, 3);
    chk("t5_cpu_acks", cpu_ack_cnt - c0, 0);
    host_halt = 0;
    count_grants(1, seq, n);
    chk("t5_after_halt", seq[0], 2'd1);
    wait_idle("t5b");
    cpu_req = 0; host_req = 0;
    step(); step();

    // 6: reset on the edge that ends the write's RAM cycle
    c0 = cpu_ack_cnt;
    cpu_we = 1; cpu_addr = 8'd102; cpu_wdata = 16'h1234; cpu_req = 1;
    step();
    chk("t6_in_access", mem_en, 1);
    rst = 1; cpu_req = 0;
    step(); step();
    rst = 0;
    for (int k = 0; k < 6; k++) step();
    chk("t6_ram", ram[102], 16'h1234);
    chk("t6_no_ack", cpu_ack_cnt - c0, 0);
    chk("t6_idle", owner, 0);
    do_access(0, 0, 8'd102, 16'h0, rd, lat);
    chk("t6_readback", rd, 16'h1234);
    wait_idle("t6");

    // Random traffic with hold-until-ack discipline and random halt
    for (int n2 = 0; n2 < 3000; n2++) begin
      step();
      if (cpu_req && cpu_ack) begin
        if ($urandom_range(0, 1) == 0) cpu_req = 0; else new_cpu();
      end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        new_cpu(); cpu_req = 1;
      end
      if (host_req && host_ack) begin
        if ($urandom_range(0, 1) == 0) host_req = 0; else new_host();
      end else if (!host_req && $urandom_range(0, 3) == 0) begin
        new_host(); host_req = 1;
      end
      if ($urandom_range(0, 19) == 0) host_halt = ~host_halt;
    end
    cpu_req = 0; host_req = 0; host_halt = 0;
    for (int k = 0; k < 8; k++) step();
    n = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== model_mem[i]) n++;
    chk("final_ram_contents", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
